seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_pkg.sv | 31 +++
 rtl/seq_divider_step.sv | 24 ++
 rtl/seq_divider.sv | 151 +++++++++++++++
 tb/tb_seq_divider.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared core definitions: ALU op/func encodings, divider FSM states and
// small helpers used by the sequential divider.
package seq_divider_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  // ALU opcode and funct7 that select the M-extension unit
  localparam logic [6:0] OP_ALU        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNC_MUL    = 3'b000;
  localparam logic [2:0] FUNC_MULH   = 3'b001;
  localparam logic [2:0] FUNC_MULHSU = 3'b010;
  localparam logic [2:0] FUNC_MULHU  = 3'b011;
  localparam logic [2:0] FUNC_DIV    = 3'b100;
  localparam logic [2:0] FUNC_DIVU   = 3'b101;
  localparam logic [2:0] FUNC_REM    = 3'b110;
  localparam logic [2:0] FUNC_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the
// divisor and keep the difference when it does not borrow.
module div_iter_step
  import seq_divider_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor always holds, so bit XLEN of diff is a clean borrow flag
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, divisor_i};
    rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], ~diff[XLEN]};
  end

endmodule

// File: rtl/seq_divider.sv
// 32-bit sequential restoring divider (DIV/DIVU/REM/REMU), one quotient bit
// per clock, with optional single-cycle completion of the special cases.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            aclk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] din1,
  input  logic [XLEN-1:0] din2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] dout,
  output state_e          dbg_state_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN-1:0]   spec_res_q, spec_res_d;
  logic [XLEN-1:0]   dout_q, dout_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_rem_q, is_rem_d;
  logic              special_q, special_d;

  logic              in_signed, in_rem, in_div_zero, in_ovf, in_special;
  logic [XLEN-1:0]   in_spec_res, mag1, mag2;
  logic [XLEN-1:0]   step_rem, step_quo, result;

  div_iter_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Operand decode; unknown func codes fall through as DIVU
  always_comb begin
    in_signed   = (func == FUNC_DIV) || (func == FUNC_REM);
    in_rem      = (func == FUNC_REM) || (func == FUNC_REMU);
    in_div_zero = (din2 == '0);
    in_ovf      = in_signed && (din1 == 32'h8000_0000) && (din2 == 32'hFFFF_FFFF);
    in_special  = in_div_zero || in_ovf;
    if (in_div_zero) begin
      in_spec_res = in_rem ? din1 : 32'hFFFF_FFFF;
    end else begin
      in_spec_res = in_rem ? 32'h0 : 32'h8000_0000;
    end
    mag1 = neg_if(in_signed && din1[XLEN-1], din1);
    mag2 = neg_if(in_signed && din2[XLEN-1], din2);
  end

  // Result of the final step, sign-corrected, or the precomputed special value
  always_comb begin
    if (special_q) begin
      result = spec_res_q;
    end else if (is_rem_q) begin
      result = neg_if(neg_rem_q, step_rem);
    end else begin
      result = neg_if(neg_quo_q, step_quo);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    spec_res_d = spec_res_q;
    dout_d     = dout_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    is_rem_d   = is_rem_q;
    special_d  = special_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d      = '0;
          quo_d      = mag1;
          divisor_d  = mag2;
          neg_quo_d  = in_signed && (din1[XLEN-1] ^ din2[XLEN-1]);
          neg_rem_d  = in_signed && din1[XLEN-1];
          is_rem_d   = in_rem;
          special_d  = in_special;
          spec_res_d = in_spec_res;
          cnt_d      = '0;
          if (EARLY_OUT && in_special) begin
            dout_d  = in_spec_res;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == {CNT_W{1'b1}}) begin
          dout_d  = result;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      spec_res_q <= '0;
      dout_q     <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_rem_q   <= 1'b0;
      special_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      spec_res_q <= spec_res_d;
      dout_q     <= dout_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      is_rem_q   <= is_rem_d;
      special_q  <= special_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign dout        = dout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: two instances (early-out on and off) share stimulus;
// a negedge monitor checks results and latency against queued expectations.
module tb_seq_divider;
  import seq_divider_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  func = 3'b000;
  logic [31:0] din1 = '0;
  logic [31:0] din2 = '0;
  logic        busy1, done1, busy0, done0;
  logic [31:0] dout1, dout0;
  state_e      st1, st0;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        rst_seen = 1'b1;
  logic [31:0] last1 = '0;
  logic [31:0] last0 = '0;

  logic [31:0] exp1_q[$], exp0_q[$];
  int          lat1_q[$], lat0_q[$], t1_q[$], t0_q[$];

  seq_divider #(.EARLY_OUT(1'b1)) dut1 (
    .aclk(clk), .rst(rst), .start(start), .func(func), .din1(din1), .din2(din2),
    .busy(busy1), .done(done1), .dout(dout1), .dbg_state_o(st1)
  );

  seq_divider #(.EARLY_OUT(1'b0)) dut0 (
    .aclk(clk), .rst(rst), .start(start), .func(func), .din1(din1), .din2(din2),
    .busy(busy0), .done(done0), .dout(dout0), .dbg_state_o(st0)
  );

  // clock / reset bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: plain 64-bit arithmetic on the architectural rules
  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic   sgn, rm;
    longint sa, sb;
    sgn = (f == 3'b100) || (f == 3'b110);
    rm  = (f == 3'b110) || (f == 3'b111);
    if (b == 0) return rm ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return rm ? 32'(sa % sb) : 32'(sa / sb);
    end
    return rm ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    sgn = (f == 3'b100) || (f == 3'b110);
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // driver: call just after a negedge; start is seen on the next posedge
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
    logic [31:0] e;
    func  = f;
    din1  = a;
    din2  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e = ref_div(f, a, b);
      exp1_q.push_back(e);
      exp0_q.push_back(e);
      // done appears in the cycle after the start edge (early-out) or 32 edges later
      lat1_q.push_back(is_special(f, a, b) ? 0 : 32);
      lat0_q.push_back(32);
      t1_q.push_back(cyc);
      t0_q.push_back(cyc);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy1 && !busy0) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL idle_timeout: busy1=%b busy0=%b after 100 cycles, required idle", busy1, busy0);
  endtask

  // scoreboard monitor for one instance
  task automatic mon(input bit id, input logic d, input logic b, input logic [31:0] o);
    logic [31:0] e;
    int          l, t, sz;
    sz = id ? exp1_q.size() : exp0_q.size();
    if (sz > 0) check($sformatf("busy%0d", id), 32'(b), 32'd1);
    if (d) begin
      if (sz == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL done%0d: unexpected done pulse with dout=%h, required none", id, o);
      end else begin
        if (id) begin
          e = exp1_q.pop_front(); l = lat1_q.pop_front(); t = t1_q.pop_front();
        end else begin
          e = exp0_q.pop_front(); l = lat0_q.pop_front(); t = t0_q.pop_front();
        end
        check($sformatf("dout%0d", id), o, e);
        check($sformatf("latency%0d", id), 32'(cyc - t), 32'(l));
        if (id) last1 = e; else last0 = e;
      end
    end else begin
      check($sformatf("hold%0d", id), o, id ? last1 : last0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_seen) begin
      last1 = '0;
      last0 = '0;
    end else begin
      mon(1'b1, done1, busy1, dout1);
      mon(1'b0, done0, busy0, dout0);
    end
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int          r;

    repeat (3) @(negedge clk);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_dout1", dout1, 32'd0);
    check("rst_dout0", dout0, 32'd0);
    rst = 1'b0;

    // first start on the edge right after reset release
    issue(FUNC_DIVU, 32'd100, 32'd7, 1'b1);
    wait_idle();
    issue(FUNC_REM,  32'hFFFF_FFF9, 32'd2, 1'b1); wait_idle();
    issue(FUNC_DIV,  32'hFFFF_FFF9, 32'd2, 1'b1); wait_idle();
    issue(FUNC_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
    issue(FUNC_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
    issue(FUNC_DIVU, 32'd5, 32'd0, 1'b1); wait_idle();
    issue(FUNC_REMU, 32'd5, 32'd0, 1'b1); wait_idle();
    issue(FUNC_REM,  32'hFFFF_FFFB, 32'd0, 1'b1); wait_idle();
    issue(FUNC_DIV,  32'hFFFF_FFFB, 32'd0, 1'b1); wait_idle();
    issue(3'b001,    32'hF000_0000, 32'd3, 1'b1); wait_idle();
    issue(FUNC_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_idle();

    // a start pulse mid-calculation must be dropped
    issue(FUNC_DIVU, 32'd1000, 32'd7, 1'b1);
    repeat (4) @(negedge clk);
    func  = FUNC_DIV;
    din1  = 32'd12345;
    din2  = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // reset in the middle of CALC aborts without a done pulse
    issue(FUNC_DIVU, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy1", 32'(busy1), 32'd0);
    check("abort_done1", 32'(done1), 32'd0);
    check("abort_dout1", dout1, 32'd0);
    check("abort_busy0", 32'(busy0), 32'd0);
    check("abort_done0", 32'(done0), 32'd0);
    check("abort_dout0", dout0, 32'd0);
    rst = 1'b0;
    issue(FUNC_DIVU, 32'd9, 32'd3, 1'b1);
    wait_idle();

    // randomized operations with a bias toward corner operands
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0)      b = 32'd0;
      else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (r == 2) b = 32'($urandom_range(1, 15));
      else if (r == 3) b = -32'($urandom_range(1, 15));
      else             b = $urandom;
      issue(f, a, b, 1'b1);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("drain1", 32'(exp1_q.size()), 32'd0);
    check("drain0", 32'(exp0_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
